// File: rtl/isram_ahbl_arbiter.sv
// isram_ahbl_arbiter
// Two-master AHB-Lite arbiter in front of the single-port instruction SRAM.
// m0 is the core instruction-fetch master, m1 the loader/debug/data master.
// Arbitration is round-robin, with burst (SEQ) and hmastlock hold. An
// uncontended master sees zero added latency.
//
// Handshake: an address phase is accepted on a rising edge where the master
// drives htrans[1]=1 and its hready=1. A data phase completes on a rising edge
// where its owner sees hready=1. A master that sees hready=0 holds its address,
// control and write data stable. While s_hready=0, every register here holds.
//
// If a master's data phase completes in the same cycle that its next address
// phase loses arbitration, that master must still see hready=0. Its read
// response is therefore parked in a one-entry buffer. It is replayed together
// with hready=1 in the cycle where the master finally wins.
module isram_ahbl_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0 (instruction fetch)
    input  logic [ADDR_WIDTH-1:0] m0_haddr,
    input  logic [2:0]            m0_hburst,
    input  logic                  m0_hmastlock,
    input  logic [3:0]            m0_hprot,
    input  logic [2:0]            m0_hsize,
    input  logic [1:0]            m0_htrans,
    input  logic [DATA_WIDTH-1:0] m0_hwdata,
    input  logic                  m0_hwrite,
    output logic [DATA_WIDTH-1:0] m0_hrdata,
    output logic                  m0_hready,
    output logic                  m0_hresp,
    // master 1 (loader / debug / data)
    input  logic [ADDR_WIDTH-1:0] m1_haddr,
    input  logic [2:0]            m1_hburst,
    input  logic                  m1_hmastlock,
    input  logic [3:0]            m1_hprot,
    input  logic [2:0]            m1_hsize,
    input  logic [1:0]            m1_htrans,
    input  logic [DATA_WIDTH-1:0] m1_hwdata,
    input  logic                  m1_hwrite,
    output logic [DATA_WIDTH-1:0] m1_hrdata,
    output logic                  m1_hready,
    output logic                  m1_hresp,
    // ISRAM slave port
    output logic [ADDR_WIDTH-1:0] s_haddr,
    output logic [2:0]            s_hburst,
    output logic                  s_hmastlock,
    output logic [3:0]            s_hprot,
    output logic [2:0]            s_hsize,
    output logic [1:0]            s_htrans,
    output logic [DATA_WIDTH-1:0] s_hwdata,
    output logic                  s_hwrite,
    input  logic [DATA_WIDTH-1:0] s_hrdata,
    input  logic                  s_hready,
    input  logic                  s_hresp
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    // Arbitration and data-phase tracking state
    logic                  grant;    // master that owned the last accepted address phase
    logic                  dvalid;   // a data phase is in flight
    logic                  downer;   // owner of the in-flight data phase
    logic                  rr_last;  // last winner, used to break ties
    logic                  hold0;
    logic                  hold1;
    logic [DATA_WIDTH-1:0] buf0_rdata;
    logic [DATA_WIDTH-1:0] buf1_rdata;
    logic                  buf0_resp;
    logic                  buf1_resp;

    // Combinational arbitration results
    logic req0;
    logic req1;
    logic keep0;
    logic keep1;
    logic win_valid;
    logic winner;
    logic sel;
    logic cap0;
    logic cap1;

    // Pick this cycle's address-phase winner. The current owner keeps the
    // bus through a SEQ burst or a locked sequence.
    always_comb begin
        req0  = m0_htrans[1] | hold0;
        req1  = m1_htrans[1] | hold1;
        keep0 = dvalid && (grant == 1'b0) &&
                ((m0_htrans == HTRANS_SEQ) || (m0_hmastlock && (m0_htrans != HTRANS_IDLE)));
        keep1 = dvalid && (grant == 1'b1) &&
                ((m1_htrans == HTRANS_SEQ) || (m1_hmastlock && (m1_htrans != HTRANS_IDLE)));
        win_valid = 1'b0;
        winner    = 1'b0;
        if (keep0) begin
            win_valid = 1'b1;
            winner    = 1'b0;
        end else if (keep1) begin
            win_valid = 1'b1;
            winner    = 1'b1;
        end else if (req0 && req1) begin
            win_valid = 1'b1;
            winner    = ~rr_last;
        end else if (req0) begin
            win_valid = 1'b1;
            winner    = 1'b0;
        end else if (req1) begin
            win_valid = 1'b1;
            winner    = 1'b1;
        end
        // With no winner, stay parked on the last owner's address/control.
        sel = win_valid ? winner : grant;
        // A requesting data-phase owner that loses the address phase has its
        // response captured into its buffer.
        cap0 = dvalid && (downer == 1'b0) && s_hready && req0 && !(win_valid && (winner == 1'b0));
        cap1 = dvalid && (downer == 1'b1) && s_hready && req1 && !(win_valid && (winner == 1'b1));
    end

    // Slave-side mux: address/control follow the winner, write data the data-phase owner
    always_comb begin
        if (sel == 1'b0) begin
            s_haddr     = m0_haddr;
            s_hburst    = m0_hburst;
            s_hmastlock = m0_hmastlock;
            s_hprot     = m0_hprot;
            s_hsize     = m0_hsize;
            s_hwrite    = m0_hwrite;
            s_htrans    = win_valid ? m0_htrans : HTRANS_IDLE;
        end else begin
            s_haddr     = m1_haddr;
            s_hburst    = m1_hburst;
            s_hmastlock = m1_hmastlock;
            s_hprot     = m1_hprot;
            s_hsize     = m1_hsize;
            s_hwrite    = m1_hwrite;
            s_htrans    = win_valid ? m1_htrans : HTRANS_IDLE;
        end
        s_hwdata = (downer == 1'b0) ? m0_hwdata : m1_hwdata;
    end

    // Master 0 response: a winner follows the slave, a loser stalls, an idle
    // master either finishes its data phase or sees the bus as ready.
    always_comb begin
        if (win_valid && (winner == 1'b0)) begin
            m0_hready = s_hready;
        end else if (req0) begin
            m0_hready = 1'b0;
        end else if (dvalid && (downer == 1'b0)) begin
            m0_hready = s_hready;
        end else begin
            m0_hready = 1'b1;
        end
        // Live slave data only while m0 owns a data phase and has nothing
        // parked; otherwise show the buffer (zero after reset).
        if (!hold0 && dvalid && (downer == 1'b0)) begin
            m0_hrdata = s_hrdata;
            m0_hresp  = s_hresp;
        end else begin
            m0_hrdata = buf0_rdata;
            m0_hresp  = buf0_resp;
        end
    end

    // Master 1 response, mirror of master 0
    always_comb begin
        if (win_valid && (winner == 1'b1)) begin
            m1_hready = s_hready;
        end else if (req1) begin
            m1_hready = 1'b0;
        end else if (dvalid && (downer == 1'b1)) begin
            m1_hready = s_hready;
        end else begin
            m1_hready = 1'b1;
        end
        if (!hold1 && dvalid && (downer == 1'b1)) begin
            m1_hrdata = s_hrdata;
            m1_hresp  = s_hresp;
        end else begin
            m1_hrdata = buf1_rdata;
            m1_hresp  = buf1_resp;
        end
    end

    // Advance arbitration, data-phase tracking and response buffers only when the slave is ready
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= 1'b0;
            dvalid     <= 1'b0;
            downer     <= 1'b0;
            rr_last    <= 1'b1;
            hold0      <= 1'b0;
            hold1      <= 1'b0;
            buf0_rdata <= '0;
            buf1_rdata <= '0;
            buf0_resp  <= 1'b0;
            buf1_resp  <= 1'b0;
        end else if (s_hready) begin
            dvalid <= win_valid;
            if (win_valid) begin
                downer  <= winner;
                grant   <= winner;
                rr_last <= winner;
            end
            if (cap0) begin
                buf0_rdata <= s_hrdata;
                buf0_resp  <= s_hresp;
                hold0      <= 1'b1;
            end else if (hold0 && win_valid && (winner == 1'b0)) begin
                hold0 <= 1'b0;
            end
            if (cap1) begin
                buf1_rdata <= s_hrdata;
                buf1_resp  <= s_hresp;
                hold1      <= 1'b1;
            end else if (hold1 && win_valid && (winner == 1'b1)) begin
                hold1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isram_ahbl_arbiter.sv
// Directed bench for isram_ahbl_arbiter with a 1-cycle-latency SRAM slave model.
// SRAM word i resets to 32'hA000_0000 | i, where i = haddr[9:2].
module tb_isram_ahbl_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_haddr, m1_haddr;
  logic [2:0]  m0_hburst, m1_hburst;
  logic        m0_hmastlock, m1_hmastlock;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready;
  logic        m0_hresp, m1_hresp;
  logic [31:0] s_haddr;
  logic [2:0]  s_hburst;
  logic        s_hmastlock;
  logic [3:0]  s_hprot;
  logic [2:0]  s_hsize;
  logic [1:0]  s_htrans;
  logic [31:0] s_hwdata;
  logic        s_hwrite;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  isram_ahbl_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_haddr(m0_haddr), .m0_hburst(m0_hburst), .m0_hmastlock(m0_hmastlock),
    .m0_hprot(m0_hprot), .m0_hsize(m0_hsize), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hwrite(m0_hwrite),
    .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hburst(m1_hburst), .m1_hmastlock(m1_hmastlock),
    .m1_hprot(m1_hprot), .m1_hsize(m1_hsize), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hwrite(m1_hwrite),
    .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hburst(s_hburst), .s_hmastlock(s_hmastlock),
    .s_hprot(s_hprot), .s_hsize(s_hsize), .s_htrans(s_htrans),
    .s_hwdata(s_hwdata), .s_hwrite(s_hwrite),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // SRAM slave model: address phase registered, read data in the data phase,
  // write data sampled when the data phase completes
  logic [31:0] mem [0:255];
  logic        dphase;
  logic        dwrite;
  logic [7:0]  daddr;

  always @(posedge clk) begin
    if (rst) begin
      dphase <= 1'b0;
      dwrite <= 1'b0;
      daddr  <= 8'd0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (s_hready) begin
      if (dphase && dwrite) mem[daddr] <= s_hwdata;
      dphase <= s_htrans[1];
      daddr  <= s_haddr[9:2];
      dwrite <= s_hwrite;
    end
  end

  assign s_hrdata = (dphase && !dwrite) ? mem[daddr] : 32'd0;
  assign s_hready = ~stall;
  assign s_hresp  = 1'b0;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic [1:0] trans, input logic [31:0] addr, input logic write,
                          input logic [31:0] wdata, input logic [2:0] burst, input logic lock);
    m0_htrans = trans; m0_haddr = addr; m0_hwrite = write;
    m0_hwdata = wdata; m0_hburst = burst; m0_hmastlock = lock;
  endtask

  task automatic drive_m1(input logic [1:0] trans, input logic [31:0] addr, input logic write,
                          input logic [31:0] wdata, input logic [2:0] burst, input logic lock);
    m1_htrans = trans; m1_haddr = addr; m1_hwrite = write;
    m1_hwdata = wdata; m1_hburst = burst; m1_hmastlock = lock;
  endtask

  task automatic idle_all();
    drive_m0(2'b00, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0);
    drive_m1(2'b00, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m0_hprot = 4'b0011; m1_hprot = 4'b0011;
    m0_hsize = 3'b010;  m1_hsize = 3'b010;
    stall = 1'b0;
    do_reset();

    // reset state
    #1;
    check("rst_htrans", 32'(s_htrans), 32'd0);
    check("rst_m0_hready", 32'(m0_hready), 32'd1);
    check("rst_m1_hready", 32'(m1_hready), 32'd1);
    check("rst_m0_hresp", 32'(m0_hresp), 32'd0);
    check("rst_m1_hresp", 32'(m1_hresp), 32'd0);
    check("rst_m0_hrdata", m0_hrdata, 32'd0);
    check("rst_m1_hrdata", m1_hrdata, 32'd0);
    check("rst_dvalid", 32'(dut.dvalid), 32'd0);

    // m0 alone: 0x10 then 0x14
    drive_m0(2'b10, 32'h10, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("solo_htrans0", 32'(s_htrans), 32'd2);
    check("solo_haddr0", s_haddr, 32'h10);
    check("solo_hsize", 32'(s_hsize), 32'd2);
    check("solo_hprot", 32'(s_hprot), 32'd3);
    check("solo_rdy0", 32'(m0_hready), 32'd1);
    tick();
    drive_m0(2'b10, 32'h14, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("solo_htrans1", 32'(s_htrans), 32'd2);
    check("solo_haddr1", s_haddr, 32'h14);
    check("solo_rdy1", 32'(m0_hready), 32'd1);
    check("solo_data0", m0_hrdata, 32'hA000_0004);
    tick();
    idle_all(); #1;
    check("solo_rdy2", 32'(m0_hready), 32'd1);
    check("solo_data1", m0_hrdata, 32'hA000_0005);
    check("solo_idle", 32'(s_htrans), 32'd0);
    tick();

    // contention after reset, buffer capture on both sides
    do_reset();
    drive_m0(2'b10, 32'h100, 1'b0, 32'h0, 3'b000, 1'b0);
    drive_m1(2'b10, 32'h200, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("c1_haddr", s_haddr, 32'h100);
    check("c1_rdy0", 32'(m0_hready), 32'd1);
    check("c1_rdy1", 32'(m1_hready), 32'd0);
    tick();
    drive_m0(2'b10, 32'h104, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("c2_haddr", s_haddr, 32'h200);
    check("c2_rdy0", 32'(m0_hready), 32'd0);
    check("c2_rdy1", 32'(m1_hready), 32'd1);
    tick();
    drive_m1(2'b10, 32'h204, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("c3_haddr", s_haddr, 32'h104);
    check("c3_rdy0", 32'(m0_hready), 32'd1);
    check("c3_buf0", m0_hrdata, 32'hA000_0040);
    check("c3_rdy1", 32'(m1_hready), 32'd0);
    tick();
    drive_m0(2'b00, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("c4_hold1", 32'(dut.hold1), 32'd1);
    check("c4_haddr", s_haddr, 32'h204);
    check("c4_rdy1", 32'(m1_hready), 32'd1);
    check("c4_buf1", m1_hrdata, 32'hA000_0080);
    check("c4_rdy0", 32'(m0_hready), 32'd1);
    check("c4_data0", m0_hrdata, 32'hA000_0041);
    tick();
    idle_all(); #1;
    check("c5_data1", m1_hrdata, 32'hA000_0081);
    tick();

    // m1 INCR4 burst while m0 requests
    drive_m1(2'b10, 32'h300, 1'b0, 32'h0, 3'b011, 1'b0); #1;
    check("b1_haddr", s_haddr, 32'h300);
    tick();
    drive_m1(2'b11, 32'h304, 1'b0, 32'h0, 3'b011, 1'b0);
    drive_m0(2'b10, 32'h10, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("b2_haddr", s_haddr, 32'h304);
    check("b2_hburst", 32'(s_hburst), 32'd3);
    check("b2_rdy0", 32'(m0_hready), 32'd0);
    check("b2_data1", m1_hrdata, 32'hA000_00C0);
    tick();
    drive_m1(2'b11, 32'h308, 1'b0, 32'h0, 3'b011, 1'b0); #1;
    check("b3_haddr", s_haddr, 32'h308);
    check("b3_rdy0", 32'(m0_hready), 32'd0);
    check("b3_data1", m1_hrdata, 32'hA000_00C1);
    tick();
    drive_m1(2'b11, 32'h30C, 1'b0, 32'h0, 3'b011, 1'b0); #1;
    check("b4_haddr", s_haddr, 32'h30C);
    check("b4_rdy0", 32'(m0_hready), 32'd0);
    tick();
    drive_m1(2'b00, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("b5_haddr", s_haddr, 32'h10);
    check("b5_rdy0", 32'(m0_hready), 32'd1);
    check("b5_rdy1", 32'(m1_hready), 32'd1);
    check("b5_data1", m1_hrdata, 32'hA000_00C3);
    tick();
    idle_all(); #1;
    check("b6_data0", m0_hrdata, 32'hA000_0004);
    tick();

    // m1 locked writes while m0 waits to read
    drive_m1(2'b10, 32'h40, 1'b1, 32'h0, 3'b000, 1'b1);
    drive_m0(2'b10, 32'h48, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("l1_haddr", s_haddr, 32'h40);
    check("l1_lock", 32'(s_hmastlock), 32'd1);
    check("l1_write", 32'(s_hwrite), 32'd1);
    check("l1_rdy0", 32'(m0_hready), 32'd0);
    tick();
    drive_m1(2'b10, 32'h44, 1'b1, 32'h1111_0001, 3'b000, 1'b1); #1;
    check("l2_haddr", s_haddr, 32'h44);
    check("l2_wdata", s_hwdata, 32'h1111_0001);
    check("l2_rdy0", 32'(m0_hready), 32'd0);
    tick();
    drive_m1(2'b10, 32'h48, 1'b1, 32'h1111_0002, 3'b000, 1'b1); #1;
    check("l3_haddr", s_haddr, 32'h48);
    check("l3_rdy0", 32'(m0_hready), 32'd0);
    tick();
    drive_m1(2'b00, 32'h0, 1'b0, 32'h1111_0003, 3'b000, 1'b0); #1;
    check("l4_haddr", s_haddr, 32'h48);
    check("l4_write", 32'(s_hwrite), 32'd0);
    check("l4_wdata", s_hwdata, 32'h1111_0003);
    check("l4_rdy0", 32'(m0_hready), 32'd1);
    tick();
    drive_m0(2'b10, 32'h40, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("l5_data0", m0_hrdata, 32'h1111_0003);
    tick();
    idle_all(); #1;
    check("l6_data0", m0_hrdata, 32'h1111_0001);
    tick();

    // slave wait state while both request
    drive_m0(2'b10, 32'h20, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    tick();
    stall = 1'b1;
    drive_m0(2'b10, 32'h24, 1'b0, 32'h0, 3'b000, 1'b0);
    drive_m1(2'b10, 32'h30, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("s2_haddr", s_haddr, 32'h30);
    check("s2_rdy0", 32'(m0_hready), 32'd0);
    check("s2_rdy1", 32'(m1_hready), 32'd0);
    tick();
    stall = 1'b0; #1;
    check("s3_hold0_pre", 32'(dut.hold0), 32'd0);
    check("s3_rdy0", 32'(m0_hready), 32'd0);
    check("s3_rdy1", 32'(m1_hready), 32'd1);
    tick();
    drive_m1(2'b00, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("s4_haddr", s_haddr, 32'h24);
    check("s4_rdy0", 32'(m0_hready), 32'd1);
    check("s4_buf0", m0_hrdata, 32'hA000_0008);
    check("s4_data1", m1_hrdata, 32'hA000_000C);
    tick();
    idle_all(); #1;
    check("s5_data0", m0_hrdata, 32'hA000_0009);
    tick();

    // reset while m1 has a parked response and m0 a data phase in flight
    drive_m1(2'b10, 32'h200, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    tick();
    drive_m0(2'b10, 32'h10, 1'b0, 32'h0, 3'b000, 1'b0);
    drive_m1(2'b10, 32'h204, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("r2_haddr", s_haddr, 32'h10);
    check("r2_rdy1", 32'(m1_hready), 32'd0);
    tick();
    check("r2_hold1", 32'(dut.hold1), 32'd1);
    do_reset(); #1;
    check("r3_htrans", 32'(s_htrans), 32'd0);
    check("r3_rdy0", 32'(m0_hready), 32'd1);
    check("r3_rdy1", 32'(m1_hready), 32'd1);
    check("r3_dvalid", 32'(dut.dvalid), 32'd0);
    check("r3_hold1", 32'(dut.hold1), 32'd0);
    check("r3_data1", m1_hrdata, 32'd0);
    drive_m0(2'b10, 32'h100, 1'b0, 32'h0, 3'b000, 1'b0);
    drive_m1(2'b10, 32'h200, 1'b0, 32'h0, 3'b000, 1'b0); #1;
    check("r4_haddr", s_haddr, 32'h100);
    tick();
    idle_all();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/isram_ahbl_arbiter.md
# isram_ahbl_arbiter

Two-master AHB-Lite arbiter that shares the single-port instruction SRAM slave between the core instruction-fetch master (m0) and a secondary master (m1: loader/debug/data port). Round-robin arbitration with burst and lock hold, zero added latency for an uncontended master, and a one-entry response buffer per master so an address phase that loses arbitration never drops the master's completed data phase. Sits between the two bus masters and the ISRAM AHB-Lite slave port.

## Interface
- ADDR_WIDTH, 32, address width (system_pkg)
- DATA_WIDTH, 32, data width (system_pkg)
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- mX_haddr / mX_hburst / mX_hmastlock / mX_hprot / mX_hsize / mX_htrans / mX_hwdata / mX_hwrite  in  ADDR_WIDTH/3/1/4/3/2/DATA_WIDTH/1  master X (X=0,1) address/control/write data
- mX_hrdata  out  DATA_WIDTH  read data to master X
- mX_hready  out  1  transfer-done/stall to master X
- mX_hresp  out  1  response to master X
- s_haddr / s_hburst / s_hmastlock / s_hprot / s_hsize / s_htrans / s_hwdata / s_hwrite  out  same widths  to ISRAM slave
- s_hrdata  in  DATA_WIDTH; s_hready  in  1; s_hresp  in  1  from ISRAM slave

## Operation
- Request: reqX = mX_htrans[1] (NONSEQ/SEQ), or holdX set (see buffer).
- Registers: grant (last address-phase owner, 0/1), dvalid + downer (data-phase owner), rr_last, holdX, bufX_rdata, bufX_resp.
- Arbitration evaluated combinationally every cycle; registers update only when s_hready=1.
- Keep rule: if dvalid and grant's master drives htrans=SEQ, or hmastlock=1 with htrans≠IDLE, that master wins regardless of the other.
- Otherwise: single requester wins; both request -> master ≠ rr_last wins; none -> no winner, park on grant.
- Slave address/control mux = winner (or parked master); s_htrans forced IDLE (2'b00) when no winner.
- s_hwdata mux = downer; s_hrdata/s_hready/s_hresp routed to downer.
- On s_hready=1: dvalid <= (winner exists); downer, grant, rr_last <= winner.
- mX_hready: if X is winner -> s_hready; else if reqX -> 0 (stall, address held by master); else if dvalid and downer==X -> s_hready; else 1.
- Buffer: when downer==X, dvalid, s_hready=1 and X requests but loses, capture s_hrdata/s_hresp into bufX, set holdX. While holdX: mX_hready=0 until X wins; in that cycle mX_hready=s_hready, mX_hrdata=bufX_rdata, mX_hresp=bufX_resp; holdX clears when s_hready=1.
- mX_hrdata/mX_hresp otherwise = s_hrdata/s_hresp when downer==X, else bufX.
- Write data: slave samples hwdata at data-phase completion, while the master still drives it; no write buffering needed.
- Reset values: grant=0, rr_last=1 (m0 wins first tie), dvalid=0, holdX=0, bufX=0. After reset with both masters idle: s_htrans=IDLE, mX_hready=1, mX_hresp=0, mX_hrdata=0.

## Timing
- Uncontended transfer: address phase passes through same cycle; read data 1 cycle later (ISRAM latency); zero arbiter latency.
- Contended NONSEQ: loser stalled ≥1 cycle; granted on the next free slot.
- Burst (SEQ) or locked sequence: no switch until owner issues NONSEQ/IDLE or drops hmastlock.
- s_hready=0: all registers frozen; both mX_hready follow the stall rules above.
- Mid-operation rst: in-flight transfer abandoned, buffers and holds cleared, registers to reset values next edge.
- Simultaneous buffer capture and new winner in the same cycle: both required.

## Test plan
- m0 alone reads addr 0x10 then 0x14 -> s_htrans NONSEQ each cycle; m0_hready=1 throughout; data on next cycle.
- Both issue NONSEQ after reset (m0 0x100, m1 0x200) -> m0 wins, m1_hready=0 one cycle, then m1 granted; rr_last alternates on continued contention.
- m0 back-to-back reads with m1 contending -> m0 data captured in buf0, m0_hready=0 until regrant, then m0_hrdata=buffered word with hready=1.
- m1 INCR4 burst (NONSEQ+3 SEQ) while m0 requests -> no switch for 4 beats; m0 granted on beat 5.
- m1 hmastlock=1 for 3 NONSEQ writes while m0 requests -> m1 keeps grant; writes land in SRAM; m0 then reads written value.
- rst asserted during m1 data phase -> next cycle s_htrans=IDLE, both hready=1, dvalid=0, hold=0.
